// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and byte transform helper
// for the UART echo path.
package uart_pkg;

    localparam logic [1:0] MODE_ECHO  = 2'd0;
    localparam logic [1:0] MODE_UPPER = 2'd1;
    localparam logic [1:0] MODE_CRLF  = 2'd2;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_a     = 8'h61;
    localparam logic [7:0] ASCII_z     = 8'h7A;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        SEND_LF,
        WAIT_LF
    } tx_state_t;

    function automatic logic [7:0] to_upper8(input logic [7:0] b);
        if (b >= ASCII_a && b <= ASCII_z)
            return b - CASE_OFFSET;
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// A push while full is taken only when a pop frees a slot that cycle.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LW-1:0]     wr_cnt;
    logic [LW-1:0]     rd_cnt;
    logic              pop_en;
    logic              push_en;

    assign level   = wr_cnt - rd_cnt;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_cnt[AW-1:0]];

    // Storage array; contents need no reset since pointers gate reads
    always_ff @(posedge clk) begin
        if (push_en)
            mem[wr_cnt[AW-1:0]] <= din;
    end

    // Free-running write/read counters, one extra bit to tell full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push_en)
                wr_cnt <= wr_cnt + 1'b1;
            if (pop_en)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers bytes from uart_rx and replays them to uart_tx2,
// optionally upper-casing or expanding CR into CR LF.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LED_W  = 5,
    parameter int OVF_W  = 8
) (
    input  logic                     ICE_CLK,
    input  logic                     ICE_RST_N,
    input  logic                     rx_dv,
    input  logic [DATA_W-1:0]        rx_byte,
    input  logic [1:0]               mode,
    output logic                     tx_start,
    output logic [DATA_W-1:0]        tx_byte,
    input  logic                     tx_done,
    output logic [LED_W-1:0]         leds,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [OVF_W-1:0]         ovf_cnt
);

    tx_state_t         state;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] xf;
    logic [1:0]        mode_lat;

    assign pop = (state == IDLE) && !empty;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (ICE_CLK),
        .rst_n (ICE_RST_N),
        .push  (rx_dv),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    // LEDs mirror the low bits of every received byte, kept or dropped
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N)
            leds <= '0;
        else if (rx_dv)
            leds <= rx_byte[LED_W-1:0];
    end

    // Count bytes lost to a full FIFO, sticking at all-ones
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N)
            ovf_cnt <= '0;
        else if (rx_dv && full && !pop && ovf_cnt != '1)
            ovf_cnt <= ovf_cnt + 1'b1;
    end

    // Transform of the popped byte under the mode latched at pop time
    always_comb begin
        xf = hold;
        if (mode_lat == MODE_UPPER)
            xf[7:0] = to_upper8(hold[7:0]);
    end

    // TX sequencer: one byte in flight, optional trailing LF after CR
    always_ff @(posedge ICE_CLK or negedge ICE_RST_N) begin
        if (!ICE_RST_N) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_byte  <= '0;
            hold     <= '0;
            mode_lat <= MODE_ECHO;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_start <= 1'b0;
                    if (!empty) begin
                        hold     <= head;
                        mode_lat <= mode;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    tx_byte  <= xf;
                    tx_start <= 1'b1;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    tx_start <= 1'b0;
                    if (tx_done) begin
                        if (mode_lat == MODE_CRLF &&
                            tx_byte == DATA_W'(ASCII_CR))
                            state <= SEND_LF;
                        else
                            state <= IDLE;
                    end
                end
                SEND_LF: begin
                    tx_byte  <= DATA_W'(ASCII_LF);
                    tx_start <= 1'b1;
                    state    <= WAIT_LF;
                end
                WAIT_LF: begin
                    tx_start <= 1'b0;
                    if (tx_done)
                        state <= IDLE;
                end
                default: begin
                    tx_start <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer: echo, upper-case, CRLF,
// overflow, full push/pop collision and mid-frame reset.
module tb_uart_echo_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LED_W  = 5;
    localparam int OVF_W  = 8;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              ICE_CLK = 1'b0;
    logic              ICE_RST_N = 1'b0;
    logic              rx_dv = 1'b0;
    logic [DATA_W-1:0] rx_byte = '0;
    logic [1:0]        mode = 2'd0;
    logic              tx_start;
    logic [DATA_W-1:0] tx_byte;
    logic              tx_done = 1'b0;
    logic [LED_W-1:0]  leds;
    logic [LW-1:0]     fifo_level;
    logic [OVF_W-1:0]  ovf_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] seen_q[$];
    int start_cnt = 0;
    int b2b_cnt = 0;
    logic prev_start = 1'b0;

    uart_echo_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LED_W  (LED_W),
        .OVF_W  (OVF_W)
    ) dut (
        .ICE_CLK    (ICE_CLK),
        .ICE_RST_N  (ICE_RST_N),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .mode       (mode),
        .tx_start   (tx_start),
        .tx_byte    (tx_byte),
        .tx_done    (tx_done),
        .leds       (leds),
        .fifo_level (fifo_level),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    // Record every start pulse with the byte presented alongside it
    always @(negedge ICE_CLK) begin
        if (tx_start) begin
            seen_q.push_back(tx_byte);
            start_cnt++;
            if (prev_start)
                b2b_cnt++;
        end
        prev_start = tx_start;
    end

    task automatic send_rx(input logic [DATA_W-1:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge ICE_CLK);
        rx_dv   = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge ICE_CLK);
        tx_done = 1'b0;
    endtask

    task automatic wait_start(output logic ok, output logic [DATA_W-1:0] b);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (seen_q.size() > 0) begin
                b  = seen_q.pop_front();
                ok = 1'b1;
            end else begin
                @(negedge ICE_CLK);
            end
        end
    endtask

    task automatic test_reset();
        ICE_RST_N = 1'b0;
        repeat (3) @(negedge ICE_CLK);
        n_vec++;
        if ({tx_start, tx_byte, leds, fifo_level, ovf_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got start=%b byte=%h leds=%b lvl=%0d ovf=%0d want all 0",
                     tx_start, tx_byte, leds, fifo_level, ovf_cnt);
        end
        ICE_RST_N = 1'b1;
        @(negedge ICE_CLK);
    endtask

    task automatic test_echo();
        logic ok;
        logic [DATA_W-1:0] b;
        mode = 2'd0;
        seen_q.delete();
        send_rx(8'h41);
        @(negedge ICE_CLK);
        n_vec++;
        if (tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL echo_early_start got %b want 0", tx_start);
        end
        @(negedge ICE_CLK);
        n_vec++;
        if (tx_start !== 1'b1) begin
            n_err++;
            $display("FAIL echo_latency got start=%b want 1", tx_start);
        end
        n_vec++;
        if (tx_byte !== 8'h41) begin
            n_err++;
            $display("FAIL echo_byte got %h want 41", tx_byte);
        end
        n_vec++;
        if (leds !== 5'b00001) begin
            n_err++;
            $display("FAIL echo_leds got %b want 00001", leds);
        end
        wait_start(ok, b);
        pulse_done();
        repeat (3) @(negedge ICE_CLK);
        n_vec++;
        if (fifo_level !== '0 || seen_q.size() != 0) begin
            n_err++;
            $display("FAIL echo_idle got lvl=%0d extra=%0d want 0 0",
                     fifo_level, seen_q.size());
        end
    endtask

    task automatic test_upper();
        logic ok;
        logic [DATA_W-1:0] b;
        logic [7:0] in_v [5];
        logic [7:0] ex_v [5];
        in_v = '{8'h61, 8'h7A, 8'h5B, 8'h7B, 8'h60};
        ex_v = '{8'h41, 8'h5A, 8'h5B, 8'h7B, 8'h60};
        mode = 2'd1;
        seen_q.delete();
        for (int i = 0; i < 5; i++)
            send_rx(in_v[i]);
        for (int i = 0; i < 5; i++) begin
            wait_start(ok, b);
            n_vec++;
            if (!ok || b !== ex_v[i]) begin
                n_err++;
                $display("FAIL upper_%0d got ok=%b byte=%h want %h",
                         i, ok, b, ex_v[i]);
            end
            pulse_done();
        end
        mode = 2'd3;
        send_rx(8'h61);
        wait_start(ok, b);
        n_vec++;
        if (!ok || b !== 8'h61) begin
            n_err++;
            $display("FAIL mode3_passthru got ok=%b byte=%h want 61", ok, b);
        end
        pulse_done();
    endtask

    task automatic test_crlf();
        logic ok;
        logic [DATA_W-1:0] b;
        logic [7:0] ex_v [3];
        int base;
        ex_v = '{8'h0D, 8'h0A, 8'h58};
        mode = 2'd2;
        repeat (3) @(negedge ICE_CLK);
        seen_q.delete();
        base = start_cnt;
        send_rx(8'h0D);
        send_rx(8'h58);
        for (int i = 0; i < 3; i++) begin
            wait_start(ok, b);
            n_vec++;
            if (!ok || b !== ex_v[i]) begin
                n_err++;
                $display("FAIL crlf_%0d got ok=%b byte=%h want %h",
                         i, ok, b, ex_v[i]);
            end
            if (i == 0)
                mode = 2'd0;
            pulse_done();
        end
        repeat (10) @(negedge ICE_CLK);
        n_vec++;
        if (start_cnt - base != 3) begin
            n_err++;
            $display("FAIL crlf_pulses got %0d want 3", start_cnt - base);
        end
    endtask

    task automatic test_overflow();
        logic ok;
        logic [DATA_W-1:0] b;
        mode = 2'd0;
        seen_q.delete();
        for (int i = 0; i < DEPTH + 3; i++)
            send_rx(DATA_W'(8'h80 + i));
        repeat (3) @(negedge ICE_CLK);
        n_vec++;
        if (fifo_level !== LW'(DEPTH)) begin
            n_err++;
            $display("FAIL ovf_level got %0d want %0d", fifo_level, DEPTH);
        end
        n_vec++;
        if (ovf_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ovf_count got %0d want 2", ovf_cnt);
        end
        n_vec++;
        if (leds !== 5'h12) begin
            n_err++;
            $display("FAIL ovf_leds got %h want 12", leds);
        end
        wait_start(ok, b);
        n_vec++;
        if (!ok || b !== 8'h80) begin
            n_err++;
            $display("FAIL ovf_first got ok=%b byte=%h want 80", ok, b);
        end
        // tx_done now; the pop lands on the next edge together with a push
        pulse_done();
        send_rx(8'hA5);
        n_vec++;
        if (fifo_level !== LW'(DEPTH) || ovf_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL full_pushpop got lvl=%0d ovf=%0d want %0d 2",
                     fifo_level, ovf_cnt, DEPTH);
        end
        for (int i = 1; i <= DEPTH + 1; i++) begin
            logic [DATA_W-1:0] e;
            e = (i == DEPTH + 1) ? DATA_W'(8'hA5) : DATA_W'(8'h80 + i);
            wait_start(ok, b);
            n_vec++;
            if (!ok || b !== e) begin
                n_err++;
                $display("FAIL drain_%0d got ok=%b byte=%h want %h",
                         i, ok, b, e);
            end
            pulse_done();
        end
        repeat (5) @(negedge ICE_CLK);
        n_vec++;
        if (fifo_level !== '0 || seen_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_empty got lvl=%0d extra=%0d want 0 0",
                     fifo_level, seen_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [DATA_W-1:0] b;
        int base;
        mode = 2'd0;
        seen_q.delete();
        for (int i = 0; i < 5; i++)
            send_rx(DATA_W'(8'h11 + i));
        repeat (4) @(negedge ICE_CLK);
        n_vec++;
        if (fifo_level !== LW'(4) || tx_byte !== 8'h11) begin
            n_err++;
            $display("FAIL mid_setup got lvl=%0d byte=%h want 4 11",
                     fifo_level, tx_byte);
        end
        ICE_RST_N = 1'b0;
        #1;
        n_vec++;
        if ({tx_start, tx_byte, leds, fifo_level, ovf_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_reset got start=%b byte=%h leds=%b lvl=%0d ovf=%0d want all 0",
                     tx_start, tx_byte, leds, fifo_level, ovf_cnt);
        end
        @(negedge ICE_CLK);
        ICE_RST_N = 1'b1;
        @(negedge ICE_CLK);
        seen_q.delete();
        base = start_cnt;
        pulse_done();
        repeat (10) @(negedge ICE_CLK);
        n_vec++;
        if (start_cnt != base || fifo_level !== '0 || tx_byte !== '0) begin
            n_err++;
            $display("FAIL stray_done got starts=%0d lvl=%0d byte=%h want 0 0 00",
                     start_cnt - base, fifo_level, tx_byte);
        end
        send_rx(8'h33);
        wait_start(ok, b);
        n_vec++;
        if (!ok || b !== 8'h33) begin
            n_err++;
            $display("FAIL post_reset_echo got ok=%b byte=%h want 33", ok, b);
        end
        pulse_done();
    endtask

    task automatic test_no_back_to_back();
        n_vec++;
        if (b2b_cnt != 0) begin
            n_err++;
            $display("FAIL back_to_back got %0d want 0", b2b_cnt);
        end
    endtask

    initial begin
        @(negedge ICE_CLK);
        test_reset();
        test_echo();
        test_upper();
        test_crlf();
        test_overflow();
        test_reset_mid();
        test_no_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
